memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter: ADDR_W, default 10, byte-address width of the attached memory block.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  unit idle, can accept; transfer when req_valid && req_ready at a rising edge.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  load: 1 zero-extend, 0 sign-extend.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-012 resp_rdata  output  32  extended load data, valid with resp_valid, 0 for stores.
REQ-013 resp_error  output  1  request rejected, valid with resp_valid.
REQ-014 mem_address  output  ADDR_W  byte address to the memory block.
REQ-015 mem_write_enable  output  2  00 read, 01 byte, 10 halfword, 11 word write.
REQ-016 mem_write_value  output  32  write data, right-justified.
REQ-017 mem_read_value  input  32  aligned word containing mem_address, valid one cycle after mem_address is driven.

Function
REQ-018 The unit SHALL be an FSM with states IDLE, ISSUE, WAIT, DONE; req_ready SHALL be 1 only in IDLE.
REQ-019 On accept the unit SHALL latch all req_* fields; inputs after accept SHALL be ignored.
REQ-020 Aligned = byte always; halfword if addr[0]==0; word if addr[1:0]==00.
REQ-021 Aligned store: ISSUE drives mem_address=addr, mem_write_enable=size+1, mem_write_value=wdata for one cycle; then DONE; resp_valid exactly 2 cycles after the accept edge.
REQ-022 Aligned load: ISSUE drives mem_address, enable 00; WAIT samples mem_read_value; DONE asserts resp_valid 3 cycles after accept.
REQ-023 Load extraction: byte lane = addr[1:0], halfword lane = addr[1]; bit 7 or 15 replicated upward unless req_unsigned; word returned unchanged.
REQ-024 req_size==11 SHALL go IDLE->DONE with resp_error=1, resp_rdata=0, no memory access, resp_valid 1 cycle after accept.
REQ-025 mem_write_enable SHALL be 00 in every state except store ISSUE cycles.
REQ-026 Address increments SHALL wrap modulo 2^ADDR_W.
REQ-027 DONE SHALL last one cycle and return to IDLE; a new request SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-028 While reset is high at a rising edge: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=00, mem_address=0, mem_write_value=0.
REQ-029 Reset mid-operation SHALL abandon the request without a response; writes already committed SHALL remain, no further byte written.

Configuration
REQ-030 Macro MEM_MISALIGNED_EN: when defined, misaligned halfword/word SHALL be split into 2/4 sequential byte accesses at addr, addr+1, ... (little-endian, byte k = data[8k+7:8k]).
REQ-031 With MEM_MISALIGNED_EN, split store: one ISSUE cycle per byte, resp_valid N+1 cycles after accept (N bytes); split load: ISSUE+WAIT per byte, resp_valid 2N+1 cycles after accept, extension applied on assembled value.
REQ-032 Without MEM_MISALIGNED_EN, misaligned requests SHALL behave as REQ-024 (resp_error=1, no access).

Verification
REQ-033 Aligned word store addr 0x010, data 0xDEADBEEF -> one cycle enable 11 at 0x010; resp_valid at accept+2, resp_error 0.
REQ-034 Byte load addr 0x013, memory word 0x80FF1234, signed -> resp_rdata 0xFFFFFF80 at accept+3; unsigned -> 0x00000080.
REQ-035 Halfword load addr 0x012, same word, signed -> 0xFFFF80FF.
REQ-036 Word store addr 0x3FE, data 0x11223344: with MEM_MISALIGNED_EN -> byte writes 0x44@0x3FE, 0x33@0x3FF, 0x22@0x000, 0x11@0x001, resp at accept+5; without -> resp_error 1 at accept+1, enable stays 00.
REQ-037 req_size 11 -> resp_error 1, resp_rdata 0 at accept+1, no memory access.
REQ-038 Reset asserted during split store after 2 bytes -> only those 2 bytes changed, no resp_valid, req_ready 1 cycle after reset deasserts.

Source files
------------

// File: rtl/memory_access_unit.sv
// ============================================================================
// memory_access_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Load/store sequencer between a core request port and a byte-addressed
//   memory block. It accepts one request at a time and drives the memory
//   port for the request. For loads it extracts the addressed byte or
//   halfword and sign- or zero-extends it. It returns one response pulse
//   per accepted request. Reserved sizes are rejected without touching
//   memory. Misaligned halfword/word requests are also rejected in the
//   default build.
//
// Build option:
//   MEM_MISALIGNED_EN - when defined, a misaligned halfword/word is split
//   into 2/4 sequential byte accesses at addr, addr+1, ... in little-endian
//   order. Addresses wrap modulo 2^ADDR_W. When undefined, misaligned
//   requests are rejected exactly like the reserved size.
//
// Timing, counted in rising edges after the accept edge, to the edge at
// which resp_valid is seen high:
//   reject              : +1   (IDLE -> DONE)
//   aligned store       : +2   (ISSUE, DONE)
//   aligned load        : +3   (ISSUE, WAIT, DONE)
//   split store, N bytes: +N+1 (N x ISSUE, DONE)
//   split load,  N bytes: +2N+1 (N x {ISSUE, WAIT}, DONE)
//
// Ports:
//   clk              in   single clock, rising edge
//   reset            in   synchronous, active-high
//   req_valid        in   request present
//   req_ready        out  unit idle; transfer on req_valid && req_ready
//   req_write        in   1 store, 0 load
//   req_size         in   00 byte, 01 halfword, 10 word, 11 reserved
//   req_unsigned     in   load: 1 zero-extend, 0 sign-extend
//   req_addr         in   byte address [ADDR_W]
//   req_wdata        in   store data, right-justified
//   resp_valid       out  one-cycle completion pulse
//   resp_rdata       out  extended load data (0 for stores/rejects)
//   resp_error       out  request rejected
//   mem_address      out  byte address to memory [ADDR_W]
//   mem_write_enable out  00 read, 01 byte, 10 halfword, 11 word write
//   mem_write_value  out  write data, right-justified
//   mem_read_value   in   aligned word containing mem_address, valid one
//                         cycle after mem_address is driven
// ============================================================================

module memory_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_write_enable,
    output logic [31:0]       mem_write_value,
    input  logic [31:0]       mem_read_value
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] WE_READ = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;

`ifdef MEM_MISALIGNED_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_write;       // latched request fields
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic              r_split;       // request runs as a byte sequence
    logic [1:0]        r_byte_idx;    // byte currently being accessed
    logic [1:0]        r_last_idx;    // index of the final byte (1 or 3)
    logic [31:0]       r_asm;         // load bytes gathered so far
    logic [ADDR_W-1:0] r_mem_address;
    logic [1:0]        r_mem_we;
    logic [31:0]       r_mem_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_error;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_aligned;
    logic              w_reject;
    logic              w_split_start;
    logic [1:0]        w_issue_we;
    logic [31:0]       w_issue_wdata;
    logic              w_more_bytes;
    logic [1:0]        w_next_idx;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [31:0]       w_store_byte;
    logic [31:0]       w_load_byte;
    logic [31:0]       w_asm_next;
    logic [31:0]       w_aligned_lane;
    logic [31:0]       w_load_result;

    // Extend the low byte/halfword of a value according to the access size.
    function automatic logic [31:0] extend_load(input logic [31:0] value,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [31:0] result;
        case (size)
            SIZE_BYTE: result = {{24{value[7]  & ~is_unsigned}}, value[7:0]};
            SIZE_HALF: result = {{16{value[15] & ~is_unsigned}}, value[15:0]};
            default:   result = value;
        endcase
        return result;
    endfunction

    always_comb begin
        // NOTE: every signal driven in an always_comb gets a value on every
        // path (here via the case default), otherwise a latch is inferred.
        case (req_size)
            SIZE_BYTE: w_aligned = 1'b1;
            SIZE_HALF: w_aligned = ~req_addr[0];
            SIZE_WORD: w_aligned = (req_addr[1:0] == 2'b00);
            default:   w_aligned = 1'b0;
        endcase
    end

    // Reserved size never aligns, so one term covers both reject causes
    // when splitting is compiled out.
    assign w_reject      = (req_size == SIZE_RSVD) || (!w_aligned && !SPLIT_EN);
    assign w_split_start = !w_aligned && SPLIT_EN && (req_size != SIZE_RSVD);

    // Memory drive for the first ISSUE cycle. A split store starts with
    // byte 0; an aligned store writes the whole request in one cycle with
    // enable = size + 1.
    assign w_issue_we    = !req_write    ? WE_READ :
                           w_split_start ? WE_BYTE :
                                           req_size + 2'd1;
    assign w_issue_wdata = !req_write    ? 32'h0 :
                           w_split_start ? {24'h0, req_wdata[7:0]} :
                                           req_wdata;

    // Byte-sequence bookkeeping (constant-false when splitting is disabled,
    // because r_split can then never be set).
    assign w_more_bytes = r_split && (r_byte_idx != r_last_idx);
    assign w_next_idx   = r_byte_idx + 2'd1;
    assign w_addr_inc   = r_mem_address + ADDR_ONE;   // wraps naturally
    assign w_store_byte = 32'h0000_00FF & (r_wdata >> {w_next_idx, 3'b000});

    // Byte lane of the current address within the returned word, and the
    // little-endian assembly of a split load.
    assign w_load_byte = 32'h0000_00FF & (mem_read_value >> {r_mem_address[1:0], 3'b000});
    assign w_asm_next  = r_asm | (w_load_byte << {r_byte_idx, 3'b000});

    // Aligned load: right-justify the addressed lane; extend_load discards
    // whatever sits above it.
    always_comb begin
        w_aligned_lane = mem_read_value;
        case (r_size)
            SIZE_BYTE: w_aligned_lane = mem_read_value >> {r_mem_address[1:0], 3'b000};
            SIZE_HALF: w_aligned_lane = mem_read_value >> {r_mem_address[1], 4'b0000};
            default:   ;
        endcase
    end

    assign w_load_result = extend_load(r_split ? w_asm_next : w_aligned_lane,
                                       r_size, r_unsigned);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // NOTE: state registers are assigned with non-blocking (<=) so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_size        <= SIZE_BYTE;
            r_unsigned    <= 1'b0;
            r_wdata       <= 32'h0;
            r_split       <= 1'b0;
            r_byte_idx    <= 2'd0;
            r_last_idx    <= 2'd0;
            r_asm         <= 32'h0;
            r_mem_address <= '0;
            r_mem_we      <= WE_READ;
            r_mem_wdata   <= 32'h0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'h0;
            r_resp_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // req_ready is high in IDLE, so req_valid alone accepts.
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        r_byte_idx <= 2'd0;
                        r_last_idx <= (req_size == SIZE_WORD) ? 2'd3 : 2'd1;
                        r_asm      <= 32'h0;
                        if (w_reject) begin
                            // No memory access at all; respond next cycle.
                            r_split      <= 1'b0;
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_split       <= w_split_start;
                            r_state       <= S_ISSUE;
                            r_mem_address <= req_addr;
                            r_mem_we      <= w_issue_we;
                            r_mem_wdata   <= w_issue_wdata;
                        end
                    end
                end

                S_ISSUE: begin
                    if (r_write) begin
                        if (w_more_bytes) begin
                            // Next byte of a split store: one write per cycle.
                            r_byte_idx    <= w_next_idx;
                            r_mem_address <= w_addr_inc;
                            r_mem_wdata   <= w_store_byte;
                        end else begin
                            r_mem_we     <= WE_READ;
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b0;
                            r_resp_rdata <= 32'h0;
                        end
                    end else begin
                        // Read data for this address arrives next cycle.
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (w_more_bytes) begin
                        r_asm         <= w_asm_next;
                        r_byte_idx    <= w_next_idx;
                        r_mem_address <= w_addr_inc;
                        r_state       <= S_ISSUE;
                    end else begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b0;
                        r_resp_rdata <= w_load_result;
                    end
                end

                default: begin  // S_DONE: single-cycle response, then idle
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready        = (r_state == S_IDLE);
    assign resp_valid       = r_resp_valid;
    assign resp_rdata       = r_resp_rdata;
    assign resp_error       = r_resp_error;
    assign mem_address      = r_mem_address;
    assign mem_write_enable = r_mem_we;
    assign mem_write_value  = r_mem_wdata;

endmodule

// File: tb/tb_memory_access_unit.sv
// ============================================================================
// tb_memory_access_unit
// ----------------------------------------------------------------------------
// Scoreboard bench for memory_access_unit. The driver issues requests and
// pushes the expected response (data, error, cycle of arrival) computed by a
// byte-array reference model. The monitor pops and compares on every
// resp_valid. A behavioural memory block answers the DUT's memory port, and
// its contents and write-cycle count are compared against the model.
// Build with +define+MEM_MISALIGNED_EN to exercise the split-access variant.
// ============================================================================
`timescale 1ns/1ps

module tb_memory_access_unit;

    localparam int AW        = 10;
    localparam int MEM_BYTES = 1 << AW;

`ifdef MEM_MISALIGNED_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic [AW-1:0] mem_address;
    logic [1:0]    mem_write_enable;
    logic [31:0]   mem_write_value;
    logic [31:0]   mem_read_value;

    memory_access_unit #(.ADDR_W(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_value  (mem_write_value),
        .mem_read_value   (mem_read_value)
    );

    always #5 clk = ~clk;

    // Cycle counter: value after each rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural memory block: synchronous read of the aligned word,
    // byte/halfword/word writes at mem_address.
    // ------------------------------------------------------------------
    logic [7:0] dev_mem [MEM_BYTES];
    int         dev_writes = 0;

    always @(posedge clk) begin : mem_device
        int b;
        int a;
        b = int'({mem_address[AW-1:2], 2'b00});
        a = int'(mem_address);
        mem_read_value <= {dev_mem[b + 3], dev_mem[b + 2], dev_mem[b + 1], dev_mem[b]};
        case (mem_write_enable)
            2'b01: dev_mem[a] <= mem_write_value[7:0];
            2'b10: begin
                dev_mem[a]                       <= mem_write_value[7:0];
                dev_mem[(a + 1) % MEM_BYTES]     <= mem_write_value[15:8];
            end
            2'b11: begin
                dev_mem[a]                       <= mem_write_value[7:0];
                dev_mem[(a + 1) % MEM_BYTES]     <= mem_write_value[15:8];
                dev_mem[(a + 2) % MEM_BYTES]     <= mem_write_value[23:16];
                dev_mem[(a + 3) % MEM_BYTES]     <= mem_write_value[31:24];
            end
            default: ;
        endcase
        if (mem_write_enable == 2'b01 || mem_write_enable == 2'b10 || mem_write_enable == 2'b11)
            dev_writes <= dev_writes + 1;
    end

    // ------------------------------------------------------------------
    // Reference model: memory as a byte array, requests as N-byte spans.
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [MEM_BYTES];
    int         exp_writes = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at_cyc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic model_req(input  logic          wr,
                             input  logic [1:0]    sz,
                             input  logic          uns,
                             input  logic [AW-1:0] addr,
                             input  logic [31:0]   wd,
                             output logic [31:0]   rdata,
                             output logic          err,
                             output int            lat);
        int          n;
        bit          aligned;
        logic [31:0] val;
        rdata = 32'h0;
        err   = 1'b0;
        lat   = 1;
        if (sz == 2'b11) begin
            err = 1'b1;
            return;
        end
        n       = 1 << sz;
        aligned = (int'(addr) % n) == 0;
        if (!aligned && !SPLIT) begin
            err = 1'b1;
            return;
        end
        if (wr) begin
            for (int k = 0; k < n; k++)
                ref_mem[(int'(addr) + k) % MEM_BYTES] = wd[8*k +: 8];
            exp_writes += aligned ? 1 : n;
            lat = aligned ? 2 : n + 1;
        end else begin
            val = 32'h0;
            for (int k = 0; k < n; k++)
                val = val | ({24'h0, ref_mem[(int'(addr) + k) % MEM_BYTES]} << (8*k));
            if (!uns && n < 4 && val[8*n-1])
                val = val | (32'hFFFF_FFFF << (8*n));
            rdata = val;
            lat   = aligned ? 3 : 2*n + 1;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic scramble_inputs();
        logic [31:0] r;
        r            = $urandom;
        req_valid    = 1'b0;
        req_write    = r[0];
        req_size     = r[2:1];
        req_unsigned = r[3];
        req_addr     = r[AW+3:4];
        req_wdata    = $urandom;
    endtask

    task automatic wait_ready(input string tag, output bit ok);
        int budget;
        budget = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) check({tag, " ready_timeout"}, {31'h0, req_ready}, 32'd1);
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd,
                         input string tag);
        exp_t e;
        int   lat;
        bit   ok;
        wait_ready(tag, ok);
        if (!ok) return;
        drive(wr, sz, uns, addr, wd);
        model_req(wr, sz, uns, addr, wd, e.rdata, e.err, lat);
        e.at_cyc = cyc + lat;   // accept edge is cyc+1; seen at negedge cyc+lat
        e.tag    = tag;
        exp_q.push_back(e);
        @(negedge clk);         // accept edge has passed
        scramble_inputs();      // must be ignored by the DUT
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check({tag, " pending_responses"}, exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_mem(input string tag);
        int mism;
        int first;
        mism  = 0;
        first = -1;
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (dev_mem[i] !== ref_mem[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (mism != 0)
            $display("  first differing byte at 0x%03h: memory 0x%02h, model 0x%02h",
                     first, dev_mem[first], ref_mem[first]);
        check({tag, " mem_bytes_differing"}, mism, 32'd0);
        check({tag, " write_cycles"}, dev_writes, exp_writes);
    endtask

    // ------------------------------------------------------------------
    // Monitor: one expected entry per resp_valid cycle
    // ------------------------------------------------------------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp resp_valid", {31'h0, resp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, " rdata"},   resp_rdata, mon_e.rdata);
                check({mon_e.tag, " error"},   {31'h0, resp_error}, {31'h0, mon_e.err});
                check({mon_e.tag, " arrival_cycle"}, cyc, mon_e.at_cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset in the middle of an operation: abandon without a response.
    // Split build: word store across the wrap point, reset sampled on the
    // edge that commits byte 1. Default build: aligned load, reset sampled
    // on the edge that would have entered DONE.
    // ------------------------------------------------------------------
    task automatic reset_mid_op();
        bit ok;
        wait_ready("reset_mid", ok);
        if (!ok) return;
        if (SPLIT) begin
            drive(1'b1, 2'b10, 1'b0, 10'h3FE, 32'hA5C3_5A3C);
            ref_mem[10'h3FE] = 8'h3C;
            ref_mem[10'h3FF] = 8'h5A;
            exp_writes += 2;
        end else begin
            drive(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        end
        @(negedge clk);          // after accept edge A
        scramble_inputs();
        @(negedge clk);          // after edge A+1
        reset = 1'b1;
        @(negedge clk);          // reset sampled at edge A+2
        reset = 1'b0;
        @(negedge clk);          // one cycle after deassertion
        check("reset_mid req_ready", {31'h0, req_ready}, 32'd1);
        check("reset_mid resp_valid", {31'h0, resp_valid}, 32'd0);
        check("reset_mid write_enable", {30'h0, mem_write_enable}, 32'd0);
        repeat (6) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        logic [1:0]  sz;
        logic [AW-1:0] a;

        for (int i = 0; i < MEM_BYTES; i++) begin
            r          = $urandom;
            dev_mem[i] = r[7:0];
            ref_mem[i] = r[7:0];
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset req_ready",        {31'h0, req_ready},        32'd1);
        check("reset resp_valid",       {31'h0, resp_valid},       32'd0);
        check("reset resp_rdata",       resp_rdata,                32'd0);
        check("reset resp_error",       {31'h0, resp_error},       32'd0);
        check("reset mem_write_enable", {30'h0, mem_write_enable}, 32'd0);
        check("reset mem_address",      {22'h0, mem_address},      32'd0);
        check("reset mem_write_value",  mem_write_value,           32'd0);
        reset = 1'b0;

        // Directed cases
        issue(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF, "st_word_010");
        issue(1'b0, 2'b10, 1'b0, 10'h010, 32'h0,         "ld_word_010_a");
        issue(1'b1, 2'b10, 1'b0, 10'h010, 32'h80FF_1234, "st_word_010_b");
        issue(1'b0, 2'b00, 1'b0, 10'h013, 32'h0,         "ld_byte_013_s");
        issue(1'b0, 2'b00, 1'b1, 10'h013, 32'h0,         "ld_byte_013_u");
        issue(1'b0, 2'b01, 1'b0, 10'h012, 32'h0,         "ld_half_012_s");
        issue(1'b0, 2'b01, 1'b1, 10'h012, 32'h0,         "ld_half_012_u");
        issue(1'b0, 2'b00, 1'b0, 10'h010, 32'h0,         "ld_byte_010_s");
        issue(1'b1, 2'b10, 1'b0, 10'h3FE, 32'h1122_3344, "st_word_3fe");
        issue(1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0,         "ld_word_3fe");
        issue(1'b0, 2'b01, 1'b0, 10'h3FF, 32'h0,         "ld_half_3ff");
        issue(1'b1, 2'b01, 1'b0, 10'h021, 32'hFFFF_BEEF, "st_half_021");
        issue(1'b1, 2'b11, 1'b0, 10'h040, 32'h1234_5678, "st_rsvd");
        issue(1'b0, 2'b11, 1'b1, 10'h040, 32'h0,         "ld_rsvd");
        drain("directed");
        compare_mem("directed");

        reset_mid_op();
        drain("reset_mid");
        compare_mem("reset_mid");

        // Randomized traffic: full address range plus a small window at the
        // top of memory so loads hit earlier stores and wrap-around occurs.
        for (int t = 0; t < 300; t++) begin
            r  = $urandom;
            r2 = $urandom;
            sz = r[5:4];
            if (sz == 2'b11 && r[3:0] != 4'h0) sz = 2'b10;
            a  = r[8] ? {6'h3F, r2[3:0]} : r2[AW-1:0];
            issue(r[6], sz, r[7], a, $urandom, "random");
            repeat (int'(r[10:9])) @(negedge clk);
        end
        drain("random");
        compare_mem("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
